// File: rtl/fetch_queue_if.sv
// Interface bundling the instruction memory port, the redirect input and the decode-side handshake.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   imem_addr;
    logic [31:0]   imem_rdata;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          deq_ready;
    logic          deq_valid;
    logic [31:0]   deq_inst;
    logic [31:0]   deq_pc;
    logic [31:0]   deq_pc4;
    logic [CW-1:0] count;

    modport slave (
        input  imem_rdata, redirect, redirect_pc, deq_ready,
        output imem_addr, deq_valid, deq_inst, deq_pc, deq_pc4, count
    );

    modport master (
        output imem_rdata, redirect, redirect_pc, deq_ready,
        input  imem_addr, deq_valid, deq_inst, deq_pc, deq_pc4, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, buffers fetched words in a circular
// FIFO and presents the oldest one to decode; a redirect flushes and restarts fetch.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   mem_inst [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];

    logic deq_valid;
    logic deq_fire;
    logic full;
    logic enq;

    assign deq_valid = (count != '0);
    assign deq_fire  = deq_valid & bus.deq_ready;
    assign full      = (count == DEPTH_C);
    assign enq       = ~bus.redirect & (~full | deq_fire);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (enq) begin
                wr_ptr   <= wr_ptr + PW'(1);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({enq, deq_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is never cleared; count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_inst[wr_ptr] <= bus.imem_rdata;
            mem_pc[wr_ptr]   <= fetch_pc;
        end
    end

    assign bus.imem_addr = fetch_pc;
    assign bus.count     = count;
    assign bus.deq_valid = deq_valid;
    assign bus.deq_inst  = deq_valid ? mem_inst[rd_ptr] : NOP;
    assign bus.deq_pc    = deq_valid ? mem_pc[rd_ptr] : 32'd0;
    assign bus.deq_pc4   = deq_valid ? (mem_pc[rd_ptr] + 32'd4) : 32'd0;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [31:0] model_q[$];
    logic [31:0] model_fpc;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.imem_rdata = 32'hA000_0000 | bus.imem_addr;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge: drive, compare against model, advance model, wait for next negedge.
    task automatic cycle(input logic ready, input logic redir, input logic [31:0] rpc);
        logic        fire;
        logic        was_full;
        logic [31:0] head;
        bus.deq_ready   = ready;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        #1;
        head = (model_q.size() != 0) ? model_q[0] : 32'd0;
        chk("valid", {31'd0, bus.deq_valid}, {31'd0, model_q.size() != 0});
        chk("count", 32'(bus.count), 32'(model_q.size()));
        chk("imem_addr", bus.imem_addr, model_fpc);
        chk("inst", bus.deq_inst, (model_q.size() != 0) ? (32'hA000_0000 | head) : 32'h13);
        chk("pc", bus.deq_pc, head);
        chk("pc4", bus.deq_pc4, (model_q.size() != 0) ? head + 32'd4 : 32'd0);
        if (redir) begin
            model_q.delete();
            model_fpc = {rpc[31:2], 2'b00};
        end else begin
            was_full = (model_q.size() == DEPTH);
            fire = (model_q.size() != 0) && ready;
            if (fire) void'(model_q.pop_front());
            if (!was_full || fire) begin
                model_q.push_back(model_fpc);
                model_fpc = model_fpc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.deq_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        model_q.delete();
        model_fpc = RESET_PC;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset and free-run
        chk("rst_inst", bus.deq_inst, 32'h13);
        cycle(1'b1, 1'b0, 32'd0);
        chk("c1_pc", bus.deq_pc, 32'd0);
        chk("c1_inst", bus.deq_inst, 32'hA000_0000);
        repeat (6) cycle(1'b1, 1'b0, 32'd0);

        // Fill and stall from pc 0
        cycle(1'b1, 1'b1, 32'd0);
        repeat (4) cycle(1'b0, 1'b0, 32'd0);
        chk("fill_count", 32'(bus.count), 32'd4);
        chk("fill_addr", bus.imem_addr, 32'd16);
        chk("fill_pc4", bus.deq_pc4, 32'd4);
        cycle(1'b0, 1'b0, 32'd0);
        chk("stall_addr", bus.imem_addr, 32'd16);
        chk("stall_pc", bus.deq_pc, 32'd0);

        // Full with simultaneous enqueue/dequeue
        cycle(1'b1, 1'b0, 32'd0);
        chk("fx_count", 32'(bus.count), 32'd4);
        chk("fx_pc", bus.deq_pc, 32'd4);
        chk("fx_addr", bus.imem_addr, 32'd20);

        // Redirect while full
        cycle(1'b1, 1'b1, 32'h2B);
        chk("rd_count", 32'(bus.count), 32'd0);
        chk("rd_valid", {31'd0, bus.deq_valid}, 32'd0);
        chk("rd_addr", bus.imem_addr, 32'h28);
        cycle(1'b1, 1'b0, 32'd0);
        chk("rd_pc", bus.deq_pc, 32'h28);
        chk("rd_inst", bus.deq_inst, 32'hA000_0028);

        // Drain-in-order after stall, then wrap with alternating ready
        cycle(1'b1, 1'b1, 32'd0);
        repeat (4) cycle(1'b0, 1'b0, 32'd0);
        repeat (6) cycle(1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 3 * DEPTH; i++) cycle(logic'(i % 2), 1'b0, 32'd0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            cycle(logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 19) == 0), $urandom);
        end

        // Asynchronous reset with three entries held
        cycle(1'b0, 1'b1, 32'h100);
        repeat (3) cycle(1'b0, 1'b0, 32'd0);
        chk("ar_pre_count", 32'(bus.count), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", {31'd0, bus.deq_valid}, 32'd0);
        chk("ar_count", 32'(bus.count), 32'd0);
        chk("ar_addr", bus.imem_addr, RESET_PC);
        model_q.delete();
        model_fpc = RESET_PC;
        #1 rst = 1'b0;
        repeat (5) cycle(1'b1, 1'b0, 32'd0);
        repeat (5) cycle(1'b0, 1'b0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
